// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
// Hands out exclusive framebuffer write access to one drawing client at a time,
// only while the VGA scan is in vertical blanking. Clients are served round-robin.
// An active grant is withdrawn, with a revoke pulse, as soon as active scan
// resumes. The block also produces a frame-start pulse and a free-running
// 16-bit frame counter for animation timing.
module vga_frame_scheduler #(
  parameter int HMAX    = 2047,
  parameter int VMAX    = 2047,
  parameter int VACTIVE = 1536,
  parameter int GUARD   = 4,
  parameter int NREQ    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     hcounter,
  input  logic [10:0]     vcounter,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            revoke,
  output logic            in_blank,
  output logic            frame_start,
  output logic [15:0]     frame_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [10:0] VACT_L   = 11'(VACTIVE);
  localparam logic [10:0] VMAX_L   = 11'(VMAX);
  localparam logic [10:0] HGUARD_L = 11'(HMAX - GUARD);
  localparam logic [PW:0] NREQ_L   = (PW+1)'(NREQ);

  typedef enum logic [1:0] {DISPLAY, BLANK_IDLE, BLANK_GRANT} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic            r_prevZero;

  logic            w_blankNow;
  logic            w_guardNow;
  logic            w_atZero;
  logic            w_newFrame;
  logic            w_found;
  logic [PW-1:0]   w_winner;
  logic [PW-1:0]   w_ownerNext;
  logic [NREQ-1:0] w_winnerOneHot;

  // A new grant is withheld in the last few pixels of the frame so that no
  // client is handed the bus just before it would have to be revoked again.
  assign w_blankNow     = (vcounter >= VACT_L);
  assign w_guardNow     = (vcounter == VMAX_L) && (hcounter > HGUARD_L);
  assign w_atZero       = (hcounter == 11'd0) && (vcounter == 11'd0);
  assign w_newFrame     = w_atZero && !r_prevZero;
  assign w_winnerOneHot = NREQ'(1) << w_winner;

  // Round-robin search: first requesting client at or after the pointer, wrapping.
  always_comb begin : winnerSearch
    logic [PW:0] sum;
    w_found  = 1'b0;
    w_winner = r_ptr;
    sum      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (sum >= NREQ_L) begin
        sum = sum - NREQ_L;
      end
      if (!w_found && req[sum[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = sum[PW-1:0];
      end
    end
  end

  // Pointer value that makes the client after the current owner first in line.
  always_comb begin : ownerAdvance
    logic [PW:0] nxt;
    nxt = {1'b0, r_owner} + (PW+1)'(1);
    if (nxt >= NREQ_L) begin
      nxt = '0;
    end
    w_ownerNext = nxt[PW-1:0];
  end

  // Access arbitration FSM with registered grant and revoke outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DISPLAY;
      r_ptr    <= '0;
      r_owner  <= '0;
      gnt      <= '0;
      revoke   <= 1'b0;
      in_blank <= 1'b0;
    end else begin
      revoke   <= 1'b0;
      in_blank <= w_blankNow;
      case (r_state)
        DISPLAY: begin
          gnt <= '0;
          if (w_blankNow) begin
            r_state <= BLANK_IDLE;
          end
        end
        BLANK_IDLE: begin
          if (!w_blankNow) begin
            r_state <= DISPLAY;
          end else if (w_found && !w_guardNow) begin
            gnt     <= w_winnerOneHot;
            r_owner <= w_winner;
            r_state <= BLANK_GRANT;
          end
        end
        BLANK_GRANT: begin
          if (!w_blankNow) begin
            gnt     <= '0;
            revoke  <= 1'b1;
            r_ptr   <= w_ownerNext;
            r_state <= DISPLAY;
          end else if (!req[r_owner]) begin
            gnt     <= '0;
            r_ptr   <= w_ownerNext;
            r_state <= BLANK_IDLE;
          end
        end
        default: begin
          gnt     <= '0;
          r_state <= DISPLAY;
        end
      endcase
    end
  end

  // Frame-start edge detect on (0,0); a stalled counter yields a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prevZero  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      r_prevZero  <= w_atZero;
      frame_start <= w_newFrame;
      if (w_newFrame) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler
// Directed and random bench for vga_frame_scheduler with a small scan geometry.
module tb_vga_frame_scheduler;

  localparam int HMAX    = 9;
  localparam int VMAX    = 5;
  localparam int VACTIVE = 4;
  localparam int GUARD   = 2;
  localparam int NREQ    = 2;
  localparam int LINE    = HMAX + 1;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        revoke;
    logic        inBlank;
    logic        frameStart;
    logic [15:0] count;
    logic        full;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [10:0] hcounter;
  logic [10:0] vcounter;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        revoke;
  logic        in_blank;
  logic        frame_start;
  logic [15:0] frame_count;

  exp_t  scoreQ[$];
  string tagQ[$];
  int    vectors;
  int    miscompares;
  int    hm;
  int    vm;
  int    mCount;
  bit    mPrevZero;

  vga_frame_scheduler #(
    .HMAX(HMAX), .VMAX(VMAX), .VACTIVE(VACTIVE), .GUARD(GUARD), .NREQ(NREQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hcounter(hcounter),
    .vcounter(vcounter),
    .req(req),
    .gnt(gnt),
    .revoke(revoke),
    .in_blank(in_blank),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic checkOutput();
    exp_t  e;
    string t;
    if (scoreQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = scoreQ.pop_front();
    t = tagQ.pop_front();
    cmp({t, ".in_blank"}, 16'(in_blank), 16'(e.inBlank));
    cmp({t, ".frame_start"}, 16'(frame_start), 16'(e.frameStart));
    cmp({t, ".frame_count"}, frame_count, e.count);
    if (e.full) begin
      cmp({t, ".gnt"}, 16'(gnt), 16'(e.gnt));
      cmp({t, ".revoke"}, 16'(revoke), 16'(e.revoke));
    end
    cmp({t, ".onehot0"}, 16'($onehot0(gnt)), 16'd1);
    cmp({t, ".gntOutsideBlank"}, 16'(!in_blank && (gnt != 2'b00)), 16'd0);
  endtask

  // Drive one cycle of inputs at the model's scan position, queue the
  // expected registered outputs, clock once and check.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] eg,
                               input logic er, input logic full, input string tag);
    exp_t e;
    bit   atZero;
    hcounter = 11'(hm);
    vcounter = 11'(vm);
    req      = r;
    atZero   = (hm == 0) && (vm == 0);
    e.inBlank    = (vm >= VACTIVE);
    e.frameStart = atZero && !mPrevZero;
    if (e.frameStart) mCount++;
    mPrevZero = atZero;
    e.count   = 16'(mCount);
    e.gnt     = eg;
    e.revoke  = er;
    e.full    = full;
    scoreQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic advance();
    hm++;
    if (hm > HMAX) begin
      hm = 0;
      vm++;
      if (vm > VMAX) vm = 0;
    end
  endtask

  task automatic expectReset(input string tag);
    exp_t e;
    e = '0;
    e.full = 1'b1;
    mCount    = 0;
    mPrevZero = 1'b0;
    scoreQ.push_back(e);
    tagQ.push_back(tag);
    checkOutput();
  endtask

  // Directed scenarios, random traffic and a fairness run.
  initial begin
    int         p;
    logic [1:0] r;
    logic [1:0] eg;
    logic [1:0] prevGnt;
    int         grants0;
    int         grants1;
    vectors     = 0;
    miscompares = 0;
    mCount      = 0;
    mPrevZero   = 1'b0;
    hm          = 0;
    vm          = 0;
    rst         = 1'b1;
    hcounter    = 11'd0;
    vcounter    = 11'd0;
    req         = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    expectReset("reset");

    rst = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, "firstFrame");
    repeat (5) applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, "stalledZero");
    advance();

    // Frame 1: both request, client 0 wins, drops, client 1 takes over until revoke.
    while (!(hm == 0 && vm == 0)) begin
      p  = vm * LINE + hm;
      r  = (p < 43) ? 2'b11 : 2'b10;
      eg = (p <= 40) ? 2'b00 : (p <= 42) ? 2'b01 : (p == 43) ? 2'b00 : 2'b10;
      applyStimulus(r, eg, 1'b0, 1'b1, "rrFrame");
      advance();
    end
    applyStimulus(2'b11, 2'b00, 1'b1, 1'b1, "wrapRevoke");
    advance();

    // Frame 2: pointer back at 0, then requests vanish and return inside the guard.
    while (!(hm == 0 && vm == 0)) begin
      p  = vm * LINE + hm;
      r  = (p < 42) ? 2'b11 : (p < 58) ? 2'b00 : 2'b11;
      eg = (p == 41) ? 2'b01 : 2'b00;
      applyStimulus(r, eg, 1'b0, 1'b1, "guardFrame");
      advance();
    end
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b1, "guardNoRevoke");
    advance();

    // Frame 3: pointer at 1, only client 0 asks, search wraps; reset mid-grant.
    p = 0;
    while (p < 42) begin
      p  = vm * LINE + hm;
      eg = (p >= 41) ? 2'b01 : 2'b00;
      applyStimulus(2'b01, eg, 1'b0, 1'b1, "wrapSearch");
      advance();
    end
    #2;
    rst = 1'b1;
    #1;
    expectReset("asyncReset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    hm  = 0;
    vm  = 0;

    // Random request traffic, invariants plus frame bookkeeping each cycle.
    for (int f = 0; f < 1000; f++) begin
      for (int c = 0; c < LINE * (VMAX + 1); c++) begin
        applyStimulus(2'($urandom_range(0, 3)), 2'b00, 1'b0, 1'b0, "random");
        advance();
      end
    end

    // Constant contention: grants must alternate between the two clients.
    grants0 = 0;
    grants1 = 0;
    prevGnt = 2'b00;
    for (int f = 0; f < 100; f++) begin
      for (int c = 0; c < LINE * (VMAX + 1); c++) begin
        applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, "fair");
        if (prevGnt == 2'b00 && gnt == 2'b01) grants0++;
        if (prevGnt == 2'b00 && gnt == 2'b10) grants1++;
        prevGnt = gnt;
        advance();
      end
    end
    cmp("fairTotal", 16'(grants0 + grants1), 16'd100);
    cmp("fairBalance", 16'((grants0 > grants1 + 1) || (grants1 > grants0 + 1)), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
